affine_loop_nest_ctrl: RTL and testbench

- Schedule controller that sequences one port (write or read) of a unified buffer.
- Walks a rectangular loop nest of up to NUM_DIMS dimensions at a fixed initiation interval, after a programmable start offset.
- Drives the buffer port's ctrl_vars bus and its wen/ren strobe.
- One instance per buffer port. Started by the global flush pulse.

---
 rtl/affine_loop_nest_ctrl.sv | 89 ++++++++
 tb/tb_affine_loop_nest_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/affine_loop_nest_ctrl.sv
// affine_loop_nest_ctrl: sequences one unified-buffer port through a rectangular loop nest
// at a fixed initiation interval after a programmable start offset.
module affine_loop_nest_ctrl #(
    parameter int NUM_DIMS = 4,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] cfg_extent [NUM_DIMS-1:0],
    input  logic [WIDTH-1:0] cfg_delay,
    input  logic [WIDTH-1:0] cfg_ii,
    output logic [WIDTH-1:0] ctrl_vars  [NUM_DIMS-1:0],
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_ext     [NUM_DIMS-1:0];
    logic [WIDTH-1:0] r_vars    [NUM_DIMS-1:0];
    logic [WIDTH-1:0] w_vars_nx [NUM_DIMS-1:0];
    logic [WIDTH-1:0] r_ii, r_dcnt, r_icnt;
    logic             r_busy, r_done;
    logic             w_nz, w_carry, w_at_end, w_live;

    assign ctrl_vars = r_vars;
    assign busy      = r_busy;
    assign done      = r_done;

    always_comb begin
        w_vars_nx = r_vars;
        w_nz      = 1'b1;
        w_carry   = 1'b1;
        for (int d = NUM_DIMS - 1; d >= 0; d--) begin
            w_nz         = w_nz & (r_ext[d] != '0);
            w_vars_nx[d] = w_carry ? ((r_vars[d] == r_ext[d] - WIDTH'(1)) ? '0 : r_vars[d] + WIDTH'(1)) : r_vars[d];
            w_carry      = w_carry & (r_vars[d] == r_ext[d] - WIDTH'(1));
        end
        w_at_end = w_carry;
        // The first iteration issues straight out of WAIT so that valid lands delay+1 cycles after flush.
        w_live   = (r_state == S_RUN) || (r_state == S_WAIT && r_dcnt == '0 && w_nz);
        valid    = en & w_live & (r_icnt == '0);
        last     = valid & w_at_end;
        w_next   = r_state;
        if (en && r_state == S_WAIT && r_dcnt == '0)
            w_next = (!w_nz || last) ? S_DONE : S_RUN;
        if (r_state == S_RUN && last)
            w_next = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ext   <= '{default: '0};
            r_vars  <= '{default: '0};
            r_ii    <= '0;
            r_dcnt  <= '0;
            r_icnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (flush) begin
            r_state <= S_WAIT;
            r_ext   <= cfg_extent;
            r_vars  <= '{default: '0};
            r_ii    <= (cfg_ii == '0) ? WIDTH'(1) : cfg_ii;
            r_dcnt  <= cfg_delay;
            r_icnt  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_WAIT) || (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            if (en && r_state == S_WAIT && r_dcnt != '0)
                r_dcnt <= r_dcnt - WIDTH'(1);
            if (valid) begin
                if (!last)
                    r_vars <= w_vars_nx;
                r_icnt <= r_ii - WIDTH'(1);
            end else if (en && w_live) begin
                r_icnt <= r_icnt - WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_affine_loop_nest_ctrl.sv
// tb_affine_loop_nest_ctrl: directed bench for the loop-nest schedule controller.
module tb_affine_loop_nest_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, flush, en;
    logic [15:0] cfg_extent [3:0];
    logic [15:0] cfg_delay, cfg_ii;
    logic [15:0] ctrl_vars  [3:0];
    logic        valid, last, busy, done;
    int          vectors = 0;
    int          miscompares = 0;
    int          m_ext [4];

    affine_loop_nest_ctrl #(.NUM_DIMS(4), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .en(en),
        .cfg_extent(cfg_extent), .cfg_delay(cfg_delay), .cfg_ii(cfg_ii),
        .ctrl_vars(ctrl_vars), .valid(valid), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] vars_now();
        return {ctrl_vars[0], ctrl_vars[1], ctrl_vars[2], ctrl_vars[3]};
    endfunction

    // Iteration k of the nest, innermost fastest, packed as {v0,v1,v2,v3}.
    function automatic logic [63:0] decode(input int k);
        logic [63:0] r = '0;
        for (int d = 3; d >= 0; d--) begin
            r[(3-d)*16 +: 16] = 16'(k % m_ext[d]);
            k = k / m_ext[d];
        end
        return r;
    endfunction

    task automatic set_cfg(input int e0, input int e1, input int e2, input int e3, input int dly, input int ii);
        m_ext = '{e0, e1, e2, e3};
        for (int d = 0; d < 4; d++) cfg_extent[d] = 16'(m_ext[d]);
        cfg_delay = 16'(dly);
        cfg_ii    = 16'(ii);
    endtask

    task automatic start(input int e0, input int e1, input int e2, input int e3, input int dly, input int ii);
        set_cfg(e0, e1, e2, e3, dly, ii);
        en    = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Cycle c counts edges after the flush edge; en is dropped for cycles slo..shi.
    task automatic expect_run(input string nm, input int n, input int t0, input int ii,
                              input int slo, input int shi, input int cycles);
        int k = 0;
        int due = t0;
        bit dn = 1'b0;
        bit fire;
        for (int c = 1; c <= cycles; c++) begin
            en = !(c >= slo && c <= shi);
            #1;
            fire = en && k < n && c >= due;
            chk({nm, "_valid"}, 64'(valid), 64'(fire));
            chk({nm, "_last"}, 64'(last), 64'(fire && k == n - 1));
            chk({nm, "_vars"}, vars_now(), decode(k < n ? k : n - 1));
            chk({nm, "_busy"}, 64'(busy), 64'(!dn));
            chk({nm, "_done"}, 64'(done), 64'(dn));
            if (fire) begin
                k++;
                due = c + ii;
                if (k == n) dn = 1'b1;
            end
            tick();
        end
        en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        en    = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_strobes", {61'd0, valid, busy, done}, 64'd0);
            chk("idle_vars", vars_now(), 64'd0);
            tick();
        end

        start(1, 2, 2, 3, 0, 1);
        expect_run("basic", 12, 1, 1, 0, -1, 16);

        start(1, 1, 1, 4, 5, 3);
        expect_run("dly_ii", 4, 6, 3, 0, -1, 19);

        start(1, 1, 1, 4, 0, 0);
        expect_run("ii_zero", 4, 1, 1, 0, -1, 7);

        start(1, 2, 2, 3, 0, 1);
        expect_run("stall", 12, 1, 1, 4, 6, 18);

        start(1, 2, 2, 3, 0, 1);
        expect_run("pre_abort", 12, 1, 1, 0, -1, 4);
        set_cfg(1, 1, 1, 2, 0, 1);
        flush = 1'b1;
        #1;
        chk("abort_old_valid", 64'(valid), 64'd1);
        chk("abort_old_vars", vars_now(), {16'd0, 16'd0, 16'd1, 16'd1});
        tick();
        flush = 1'b0;
        expect_run("restart", 2, 1, 1, 0, -1, 6);

        start(1, 0, 2, 3, 2, 1);
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("zero_valid", 64'(valid), 64'd0);
            chk("zero_done", 64'(done), 64'(c >= 4));
            chk("zero_busy", 64'(busy), 64'(c < 4));
            tick();
        end

        start(1, 2, 2, 3, 0, 1);
        expect_run("pre_reset", 12, 1, 1, 0, -1, 3);
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        rst_n = 1'b1;
        flush = 1'b0;
        chk("rst_vars", vars_now(), 64'd0);
        chk("rst_strobes", {61'd0, valid, busy, done}, 64'd0);
        tick();
        chk("rst_stays_idle", {61'd0, valid, busy, done}, 64'd0);
        start(1, 2, 2, 3, 0, 1);
        expect_run("post_reset", 12, 1, 1, 0, -1, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
